// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode / operand-fetch stage that feeds the 32-bit integer ALU.
// Accepts 16-bit instruction words, reads an internal 8-entry register file
// and hands registered op/a/b/rd to execute. Results come back through the
// writeback port. A per-register busy scoreboard holds issue back on RAW/WAW
// hazards until the matching writeback arrives.
//
// Instruction word: [15:14] opc, [13:11] rd, [10:8] rs1, [7:5] rs2.
//   opc 01/10/11 = ADD/SUB/MUL rd, rs1, rs2
//   opc 00       = LI rd, imm   (imm = instr[10:0] zero-extended)
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      instruction handshake, in_instr instruction word
//   out_valid/out_ready    issue handshake toward the ALU
//   out_op/out_a/out_b     ALU op code and operands
//   out_rd                 destination register, carried to writeback
//   wb_en/wb_rd/wb_data    writeback strobe, destination and value
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_rd,
    input  logic              wb_en,
    input  logic [2:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] r_regs [0:7];
    logic [7:0]        r_busy;

    logic [1:0]        w_opc;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic              w_isLi;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs1Data;
    logic [DATA_W-1:0] w_rs2Data;
    logic [7:0]        w_wbMask;
    logic [7:0]        w_effBusy;
    logic              w_hazard;
    logic              w_accept;
    logic [7:0]        w_busyNext;

    assign w_opc  = in_instr[15:14];
    assign w_rd   = in_instr[13:11];
    assign w_rs1  = in_instr[10:8];
    assign w_rs2  = in_instr[7:5];
    assign w_isLi = (w_opc == 2'b00);
    assign w_imm  = DATA_W'(in_instr[IMM_W-1:0]);

    // Operand read with same-cycle writeback bypass; r0 always reads zero,
    // even when a writeback targets it.
    always_comb begin
        w_rs1Data = '0;
        w_rs2Data = '0;
        if (w_rs1 != 3'd0) begin
            if (wb_en && wb_rd == w_rs1) w_rs1Data = wb_data;
            else                         w_rs1Data = r_regs[w_rs1];
        end
        if (w_rs2 != 3'd0) begin
            if (wb_en && wb_rd == w_rs2) w_rs2Data = wb_data;
            else                         w_rs2Data = r_regs[w_rs2];
        end
    end

    // A register whose writeback lands this cycle is no longer a hazard, so
    // the dependent instruction can issue in the same cycle via the bypass.
    assign w_wbMask  = wb_en ? (8'b1 << wb_rd) : 8'b0;
    assign w_effBusy = r_busy & ~w_wbMask;

    // LI has no source registers, only the WAW check on rd applies.
    assign w_hazard = w_isLi ? w_effBusy[w_rd]
                             : (w_effBusy[w_rs1] | w_effBusy[w_rs2] | w_effBusy[w_rd]);

    assign in_ready = !rst && (!out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Scoreboard next state: the clear from writeback is applied first so a
    // same-cycle set of the same register wins. r0 is never tracked.
    always_comb begin
        w_busyNext = r_busy;
        if (wb_en) w_busyNext[wb_rd] = 1'b0;
        if (w_accept && w_rd != 3'd0) w_busyNext[w_rd] = 1'b1;
        w_busyNext[0] = 1'b0;
    end

    // Register file and scoreboard; reset clears everything and discards any
    // writeback presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (wb_en && wb_rd != 3'd0) r_regs[wb_rd] <= wb_data;
            r_busy <= w_busyNext;
        end
    end

    // Issue register: loads on accept, otherwise holds while execute stalls
    // and empties once execute takes the pending instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op    <= 2'b00;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= 3'd0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_op    <= w_isLi ? 2'b01 : w_opc;
            out_a     <= w_isLi ? w_imm : w_rs1Data;
            out_b     <= w_isLi ? '0    : w_rs2Data;
            out_rd    <= w_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. A table of per-cycle stimulus rows
// carries the expected in_ready and, for accepted instructions, the expected
// issued op/a/b/rd. Accepted rows push their expectation into a scoreboard
// queue; a monitor pops and compares when the DUT completes an issue
// handshake and checks that pending outputs hold steady under backpressure.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_op;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [2:0]        out_rd;
    logic              wb_en;
    logic [2:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    alu_issue_stage #(.DATA_W(DATA_W), .IMM_W(11)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_op   (out_op),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_rd   (out_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    typedef struct {
        logic        rstIn;
        logic        inValid;
        logic [15:0] instr;
        logic        outReady;
        logic        wbEn;
        logic [2:0]  wbRd;
        logic [31:0] wbData;
        logic        expReady;
        logic [1:0]  expOp;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [2:0]  expRd;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rd;
    } issue_t;

    vec_t   vecs[$];
    issue_t expQ[$];
    int     compareCount = 0;
    int     failCount    = 0;
    logic   monitorOn    = 1'b0;

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(
        input logic rstIn, input logic inValid, input logic [15:0] instr,
        input logic outReady, input logic wbEn, input logic [2:0] wbRd,
        input logic [31:0] wbData, input logic expReady, input logic [1:0] expOp,
        input logic [31:0] expA, input logic [31:0] expB, input logic [2:0] expRd);
        vec_t v;
        v.rstIn = rstIn;       v.inValid = inValid;   v.instr = instr;
        v.outReady = outReady; v.wbEn = wbEn;         v.wbRd = wbRd;
        v.wbData = wbData;     v.expReady = expReady; v.expOp = expOp;
        v.expA = expA;         v.expB = expB;         v.expRd = expRd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rstIn;
        in_valid  = v.inValid;
        in_instr  = v.instr;
        out_ready = v.outReady;
        wb_en     = v.wbEn;
        wb_rd     = v.wbRd;
        wb_data   = v.wbData;
    endtask

    // Scoreboard monitor: on a completed issue handshake pop and compare; while
    // execute stalls, the pending outputs must still match the queue head.
    always @(negedge clk) begin
        if (monitorOn && !rst && out_valid) begin
            if (expQ.size() == 0) begin
                compareCount++;
                failCount++;
                $display("[TB] FAIL unexpected_issue: got op=%0d a=0x%0h b=0x%0h rd=%0d, expected no issue",
                         out_op, out_a, out_b, out_rd);
            end else begin
                checkOutput(out_ready ? "out_op" : "hold_op", 32'(out_op), 32'(expQ[0].op));
                checkOutput(out_ready ? "out_a"  : "hold_a",  out_a,        expQ[0].a);
                checkOutput(out_ready ? "out_b"  : "hold_b",  out_b,        expQ[0].b);
                checkOutput(out_ready ? "out_rd" : "hold_rd", 32'(out_rd), 32'(expQ[0].rd));
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic prevRst;
        issue_t item;

        // Row fields: rst, in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
        //             exp in_ready, exp op, exp a, exp b, exp rd
        // LI r1,5 then RAW-stalled ADD r2,r1,r1 released by bypass
        vecs.push_back(mkVec(0, 1, 16'h0805, 1, 0, 3'd0, 32'd0,  1, 2'b01, 32'd5, 32'd0, 3'd1));
        vecs.push_back(mkVec(0, 1, 16'h5120, 1, 0, 3'd0, 32'd0,  0, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'h5120, 1, 0, 3'd0, 32'd0,  0, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'h5120, 1, 1, 3'd1, 32'd5,  1, 2'b01, 32'd5, 32'd5, 3'd2));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd2, 32'd10, 1, 2'b00, 32'd0, 32'd0, 3'd0));
        // Back-to-back LI r1,9 / LI r2,4 / SUB r3,r1,r2 then 3 stall cycles
        vecs.push_back(mkVec(0, 1, 16'h0809, 1, 0, 3'd0, 32'd0,  1, 2'b01, 32'd9, 32'd0, 3'd1));
        vecs.push_back(mkVec(0, 1, 16'h1004, 1, 1, 3'd1, 32'd9,  1, 2'b01, 32'd4, 32'd0, 3'd2));
        vecs.push_back(mkVec(0, 1, 16'h9940, 1, 1, 3'd2, 32'd4,  1, 2'b10, 32'd9, 32'd4, 3'd3));
        vecs.push_back(mkVec(0, 1, 16'h2001, 0, 0, 3'd0, 32'd0,  0, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'h2001, 0, 0, 3'd0, 32'd0,  0, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'h2001, 0, 0, 3'd0, 32'd0,  0, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'h2001, 1, 0, 3'd0, 32'd0,  1, 2'b01, 32'd1, 32'd0, 3'd4));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd3, 32'd5,  1, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd4, 32'd1,  1, 2'b00, 32'd0, 32'd0, 3'd0));
        // r0 semantics: LI r0,7, MUL r4,r0,r1, wb to r0 with ADD r5,r0,r0
        vecs.push_back(mkVec(0, 1, 16'h0007, 1, 0, 3'd0, 32'd0,  1, 2'b01, 32'd7, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'hE020, 1, 0, 3'd0, 32'd0,  1, 2'b11, 32'd0, 32'd9, 3'd4));
        vecs.push_back(mkVec(0, 1, 16'h6800, 1, 1, 3'd0, 32'd7,  1, 2'b01, 32'd0, 32'd0, 3'd5));
        vecs.push_back(mkVec(0, 1, 16'h7000, 1, 1, 3'd4, 32'd9,  1, 2'b01, 32'd0, 32'd0, 3'd6));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd5, 32'h55, 1, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd6, 32'd0,  1, 2'b00, 32'd0, 32'd0, 3'd0));
        // Reset mid-flight: LI r5,3 pending, reset with a wb to r7 discarded
        vecs.push_back(mkVec(0, 1, 16'h2803, 0, 0, 3'd0, 32'd0,  1, 2'b01, 32'd3, 32'd0, 3'd5));
        vecs.push_back(mkVec(1, 0, 16'h0000, 0, 1, 3'd7, 32'h1234, 0, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 1, 16'h75E0, 1, 0, 3'd0, 32'd0,  1, 2'b01, 32'd0, 32'd0, 3'd6));
        vecs.push_back(mkVec(0, 1, 16'hBD00, 1, 1, 3'd5, 32'd3,  1, 2'b10, 32'd3, 32'd0, 3'd7));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd6, 32'd0,  1, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 1, 3'd7, 32'd3,  1, 2'b00, 32'd0, 32'd0, 3'd0));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 0, 3'd0, 32'd0,  1, 2'b00, 32'd0, 32'd0, 3'd0));

        // Power-on reset held for two cycles
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_op", 32'(out_op), 32'd0);
        checkOutput("rst_out_a", out_a, 32'd0);
        checkOutput("rst_out_b", out_b, 32'd0);
        checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready_2", 32'(in_ready), 32'd0);
        monitorOn = 1'b1;

        prevRst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            if (prevRst) expQ.delete();
            #1;
            applyStimulus(vecs[i]);
            prevRst = vecs[i].rstIn;
            @(negedge clk);
            checkOutput($sformatf("in_ready_row%0d", i), 32'(in_ready), 32'(vecs[i].expReady));
            if (vecs[i].inValid && vecs[i].expReady) begin
                item.op = vecs[i].expOp;
                item.a  = vecs[i].expA;
                item.b  = vecs[i].expB;
                item.rd = vecs[i].expRd;
                expQ.push_back(item);
            end
        end

        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
        @(negedge clk);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_queue_left", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
